// File: rtl/ram_port_uart_tx_if.sv
// Byte-lane RAM port as seen by a memory-mapped responder.
// Handshake: a write happens on any cycle with wen != 0; a read is requested on any cycle
// with ren = 1, and r_data carries the answer from the following cycle until the next read.
interface ram_port_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic [3:0]  wen;
  logic        ren;
  logic [31:0] r_data;

  modport master (output addr, output w_data, output wen, output ren, input r_data);
  modport slave  (input addr, input w_data, input wen, input ren, output r_data);
endinterface

// File: rtl/ram_port_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the byte-lane RAM port: TX FIFO, baud divisor,
// serializer FSM and a TX-empty level interrupt.
module ram_port_uart_tx #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic                   clk,
  input  logic                   rstn,
  ram_port_uart_tx_if.slave      bus,
  output logic                   uart_tx,
  output logic                   irq,
  output logic [1:0]             state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  shift_q, shift_d;
  logic [15:0] div_q, div_d, div_lat_q, div_lat_d, cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic        ovf_q, ovf_d, en_q, en_d;
  logic [31:0] r_data_q, r_data_d;
  logic        tx_d;

  logic [1:0]  sel;
  logic        wr_cyc, fifo_empty, fifo_full, push_req, push_ok, pop, busy, bit_end;
  logic        unused_ok;

  assign sel        = bus.addr[3:2];
  assign wr_cyc     = |bus.wen;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Fullness is judged before this cycle's pop, so a push into a full FIFO is always dropped.
  assign push_req   = wr_cyc && (sel == 2'd0) && bus.wen[0];
  assign push_ok    = push_req && !fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign bit_end    = (cnt_q == div_lat_q);

  assign unused_ok  = ^{bus.addr[31:4], bus.addr[1:0], bus.w_data[31:16]};

  // Serializer next-state and line output.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    div_lat_d = div_lat_q;
    tx_d      = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          shift_d   = mem_q[rd_ptr_q[AW-1:0]];
          div_lat_d = div_q;
          cnt_d     = 16'd0;
          bit_d     = 3'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          cnt_d   = 16'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          cnt_d   = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = 16'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register file, FIFO pointers and read-back; reads see the pre-write values.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    ovf_d    = ovf_q;
    div_d    = div_q;
    en_d     = en_q;
    r_data_d = r_data_q;
    if (push_req && fifo_full) ovf_d = 1'b1;
    if ((sel == 2'd1) && bus.wen[0] && bus.w_data[3]) ovf_d = 1'b0;
    if ((sel == 2'd2) && bus.wen[0]) div_d[7:0]  = bus.w_data[7:0];
    if ((sel == 2'd2) && bus.wen[1]) div_d[15:8] = bus.w_data[15:8];
    if ((sel == 2'd3) && bus.wen[0]) en_d = bus.w_data[0];
    if (bus.ren) begin
      case (sel)
        2'd1:    r_data_d = {28'd0, ovf_q, busy, fifo_empty, fifo_full};
        2'd2:    r_data_d = {16'd0, div_q};
        2'd3:    r_data_d = {31'd0, en_q};
        default: r_data_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      shift_q   <= 8'd0;
      div_q     <= DEFAULT_DIV;
      div_lat_q <= DEFAULT_DIV;
      cnt_q     <= 16'd0;
      bit_q     <= 3'd0;
      ovf_q     <= 1'b0;
      en_q      <= 1'b0;
      r_data_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      div_lat_q <= div_lat_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      ovf_q     <= ovf_d;
      en_q      <= en_d;
      r_data_q  <= r_data_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= bus.w_data[7:0];
  end

  assign uart_tx    = tx_d;
  assign irq        = en_q && fifo_empty && (state_q == S_IDLE);
  assign bus.r_data = r_data_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_ram_port_uart_tx.sv
// Bench for ram_port_uart_tx: a frame-level reference model compared against uart_tx, irq
// and r_data every cycle, plus directed scenarios pinned with literal expectations.
module tb_ram_port_uart_tx;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       uart_tx, irq;
  logic [1:0] state_dbg;
  bit         chk_en = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  ram_port_uart_tx_if bus_if ();

  ram_port_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd433)) dut (
    .clk(clk), .rstn(rstn), .bus(bus_if.slave),
    .uart_tx(uart_tx), .irq(irq), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0]  m_fifo [$];
  bit          m_active;
  int          m_t, m_d;
  logic [9:0]  m_frame;
  logic [15:0] m_div;
  bit          m_en, m_ovf;
  logic [31:0] m_r;

  function automatic logic [31:0] m_read(input logic [1:0] s);
    bit full, empty, busy;
    full  = (m_fifo.size() == DEPTH);
    empty = (m_fifo.size() == 0);
    busy  = m_active || !empty;
    case (s)
      2'd1:    return {28'd0, m_ovf, busy, empty, full};
      2'd2:    return {16'd0, m_div};
      2'd3:    return {31'd0, m_en};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_idle();
    return !m_active && (m_fifo.size() == 0);
  endfunction

  // A frame is the 10-bit pattern {stop, data, start}, each bit held for (div+1) clocks.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_fifo.delete();
      m_active = 0; m_t = 0; m_d = 0; m_frame = '1;
      m_div = 16'd433; m_en = 0; m_ovf = 0; m_r = 32'd0;
    end else begin
      bit pre_full, pre_empty;
      logic [1:0] s;
      s         = bus_if.addr[3:2];
      pre_full  = (m_fifo.size() == DEPTH);
      pre_empty = (m_fifo.size() == 0);
      if (bus_if.ren) m_r = m_read(s);
      if (m_active) begin
        m_t++;
        if (m_t == 10 * (m_d + 1)) m_active = 0;
      end else if (!pre_empty) begin
        m_frame  = {1'b1, m_fifo.pop_front(), 1'b0};
        m_d      = int'(m_div);
        m_t      = 0;
        m_active = 1;
      end
      if (s == 2'd0 && bus_if.wen[0]) begin
        if (pre_full) m_ovf = 1;
        else m_fifo.push_back(bus_if.w_data[7:0]);
      end
      if (s == 2'd1 && bus_if.wen[0] && bus_if.w_data[3]) m_ovf = 0;
      if (s == 2'd2 && bus_if.wen[0]) m_div[7:0]  = bus_if.w_data[7:0];
      if (s == 2'd2 && bus_if.wen[1]) m_div[15:8] = bus_if.w_data[15:8];
      if (s == 2'd3 && bus_if.wen[0]) m_en = bus_if.w_data[0];
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_tx;
      exp_tx = m_active ? m_frame[m_t / (m_d + 1)] : 1'b1;
      check("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx});
      check("irq", {31'd0, irq}, {31'd0, m_en && (m_fifo.size() == 0) && !m_active});
      check("r_data", bus_if.r_data, m_r);
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic [1:0] s, input logic [3:0] w, input logic [31:0] d, input logic r);
    logic [31:0] a;
    a = $urandom();
    a[3:2] = s;
    bus_if.addr   = a;
    bus_if.wen    = w;
    bus_if.w_data = d;
    bus_if.ren    = r;
    @(posedge clk); #1;
    bus_if.wen = 4'd0;
    bus_if.ren = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] pat;
    bus_if.addr = 32'd0; bus_if.w_data = 32'd0; bus_if.wen = 4'd0; bus_if.ren = 1'b0;
    #1 rstn = 1'b0;
    chk_en = 1'b1;
    idle(3);
    rstn = 1'b1;
    idle(1);

    // Reset values
    cyc(2'd2, 4'd0, 32'd0, 1'b1);
    check("reset_div", bus_if.r_data, 32'd433);
    cyc(2'd1, 4'd0, 32'd0, 1'b1);
    check("reset_status", bus_if.r_data, 32'h2);

    // Single byte, DIV=3: frame starts one clock after the write edge
    cyc(2'd2, 4'b0011, 32'd3, 1'b0);
    cyc(2'd0, 4'b0001, 32'hFFFF_FFA5, 1'b0);
    pat = 10'b1_10100101_0;
    for (int i = 0; i < 40; i++) begin
      idle(1);
      check("a5_frame_bit", {31'd0, uart_tx}, {31'd0, pat[i / 4]});
    end
    idle(1);
    check("a5_after_stop", {31'd0, uart_tx}, 32'd1);

    // Byte lanes on DIVISOR
    cyc(2'd2, 4'b0010, 32'h0000_1200, 1'b0);
    cyc(2'd2, 4'd0, 32'd0, 1'b1);
    check("div_lane1", bus_if.r_data, 32'h0000_1203);
    cyc(2'd2, 4'b1100, 32'hFFFF_FFFF, 1'b0);
    cyc(2'd2, 4'd0, 32'd0, 1'b1);
    check("div_lane32", bus_if.r_data, 32'h0000_1203);

    // Back-to-back frames at DIV=0 while polling STATUS every cycle
    cyc(2'd2, 4'b0011, 32'd0, 1'b0);
    cyc(2'd0, 4'b0001, 32'h55, 1'b0);
    cyc(2'd0, 4'b0001, 32'h0F, 1'b1);
    for (int i = 0; i < 24; i++) cyc(2'd1, 4'd0, 32'd0, 1'b1);
    check("b2b_status_done", bus_if.r_data, 32'h2);

    // IRQ, plus read-before-write on the same register
    cyc(2'd3, 4'b0001, 32'd1, 1'b0);
    check("irq_on_enable", {31'd0, irq}, 32'd1);
    cyc(2'd0, 4'b0001, 32'h81, 1'b0);
    check("irq_drop_on_push", {31'd0, irq}, 32'd0);
    idle(11);
    check("irq_after_stop", {31'd0, irq}, 32'd1);
    cyc(2'd2, 4'b0011, 32'h77, 1'b1);
    check("ren_wr_same_div", bus_if.r_data, 32'd0);
    cyc(2'd2, 4'b0011, 32'd0, 1'b0);

    // Randomized register traffic
    for (int i = 0; i < 2500; i++) begin
      logic [1:0]  s;
      logic [3:0]  w;
      logic [31:0] d;
      s = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      d = $urandom();
      if (s == 2'd2) d = {d[31:16], 8'd0, 8'($urandom_range(0, 4))};
      if (s == 2'd1 && $urandom_range(0, 3) != 0) d[3] = 1'b0;
      cyc(s, w, d, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
    end
    for (int i = 0; i < 2000 && !m_idle(); i++) idle(1);
    cyc(2'd1, 4'd0, 32'd0, 1'b1);
    check("drain_busy", {31'd0, bus_if.r_data[2]}, 32'd0);

    // Overflow with the serializer stalled on a huge divisor
    cyc(2'd1, 4'b0001, 32'h8, 1'b0);
    cyc(2'd2, 4'b0011, 32'hFFFF, 1'b0);
    for (int i = 0; i < 10; i++) cyc(2'd0, 4'b0001, 32'(8'h10 + i), 1'b0);
    cyc(2'd1, 4'd0, 32'd0, 1'b1);
    check("ovf_status", bus_if.r_data, 32'hD);
    cyc(2'd1, 4'b0001, 32'h8, 1'b1);
    check("ovf_clear_reads_old", bus_if.r_data, 32'hD);
    cyc(2'd1, 4'd0, 32'd0, 1'b1);
    check("ovf_cleared", bus_if.r_data, 32'h5);

    // Reset in the middle of a frame
    cyc(2'd2, 4'd0, 32'd0, 1'b1);
    idle(20);
    rstn = 1'b0;
    #1;
    check("midrst_tx", {31'd0, uart_tx}, 32'd1);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_rdata", bus_if.r_data, 32'd0);
    idle(2);
    rstn = 1'b1;
    idle(1);
    cyc(2'd2, 4'd0, 32'd0, 1'b1);
    check("midrst_div", bus_if.r_data, 32'd433);
    cyc(2'd1, 4'd0, 32'd0, 1'b1);
    check("midrst_status", bus_if.r_data, 32'h2);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
